// File: rtl/scroll_timing_ctrl.sv
// VGA timing sequencer with a frame-synchronous horizontal scroll offset and run/pause/step control.
// Decodes are registered one cycle behind the counters; ena low freezes all state and idles the syncs.
module scroll_timing_ctrl #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int CW       = 10
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          ena,
  input  logic [2:0]    cfg_speed,
  input  logic          cfg_dir,
  input  logic          cfg_pause,
  input  logic          cfg_load,
  input  logic          cfg_step,
  output logic          hsync_n,
  output logic          vsync_n,
  output logic          display_on,
  output logic [CW-1:0] src_x,
  output logic [CW-1:0] src_y,
  output logic [CW-1:0] scroll_x,
  output logic          frame_tick,
  output logic [1:0]    state
);

  localparam int H_TOT    = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOT    = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HS_START = H_ACTIVE + H_FP;
  localparam int HS_END   = HS_START + H_SYNC - 1;
  localparam int VS_START = V_ACTIVE + V_FP;
  localparam int VS_END   = VS_START + V_SYNC - 1;
  localparam int HW       = $clog2(H_TOT);
  localparam int VW       = $clog2(V_TOT);

  localparam logic [1:0] ST_RUN    = 2'd0;
  localparam logic [1:0] ST_PAUSED = 2'd1;
  localparam logic [1:0] ST_STEP   = 2'd2;

  logic [HW-1:0] r_hcount;
  logic [VW-1:0] r_vcount;
  logic          r_hsync_n;
  logic          r_vsync_n;
  logic          r_disp;
  logic [CW-1:0] r_src_x;
  logic [CW-1:0] r_src_y;
  logic [CW-1:0] r_scroll;
  logic          r_tick;
  logic [1:0]    r_state;
  logic [2:0]    r_pend_speed;
  logic          r_pend_dir;
  logic          r_pend_pause;
  logic [2:0]    r_act_speed;
  logic          r_act_dir;

  logic          w_h_last;
  logic          w_v_last;
  logic          w_wrap;
  logic          w_visible;
  logic          w_hs_act;
  logic          w_vs_act;
  logic          w_advance;
  logic [CW:0]   w_inc;
  logic [CW:0]   w_dec;
  logic [CW:0]   w_raw;
  logic [CW-1:0] w_scroll_nxt;
  logic [CW:0]   w_sx_sum;
  logic [CW-1:0] w_sx;
  logic [1:0]    w_state_nxt;

  assign w_h_last  = (r_hcount == HW'(H_TOT - 1));
  assign w_v_last  = (r_vcount == VW'(V_TOT - 1));
  assign w_wrap    = w_h_last && w_v_last;
  assign w_visible = (r_hcount < HW'(H_ACTIVE)) && (r_vcount < VW'(V_ACTIVE));
  assign w_hs_act  = (r_hcount >= HW'(HS_START)) && (r_hcount <= HW'(HS_END));
  assign w_vs_act  = (r_vcount >= VW'(VS_START)) && (r_vcount <= VW'(VS_END));

  // Offset wraps modulo the visible width, which is generally not a power of two.
  assign w_inc        = {1'b0, r_scroll} + {{(CW-2){1'b0}}, r_act_speed};
  assign w_dec        = {1'b0, r_scroll} + (CW+1)'(H_ACTIVE) - {{(CW-2){1'b0}}, r_act_speed};
  assign w_raw        = r_act_dir ? w_dec : w_inc;
  assign w_scroll_nxt = CW'((w_raw >= (CW+1)'(H_ACTIVE)) ? (w_raw - (CW+1)'(H_ACTIVE)) : w_raw);

  assign w_sx_sum = (CW+1)'(r_hcount) + {1'b0, r_scroll};
  assign w_sx     = CW'((w_sx_sum >= (CW+1)'(H_ACTIVE)) ? (w_sx_sum - (CW+1)'(H_ACTIVE)) : w_sx_sum);

  assign w_advance = w_wrap && ((r_state == ST_RUN) || (r_state == ST_STEP));

  // The pause that becomes active at the wrap is the pending one.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_RUN: begin
        if (w_wrap && r_pend_pause) w_state_nxt = ST_PAUSED;
      end
      ST_PAUSED: begin
        if (cfg_step)                     w_state_nxt = ST_STEP;
        else if (w_wrap && !r_pend_pause) w_state_nxt = ST_RUN;
      end
      ST_STEP: begin
        if (w_wrap) w_state_nxt = r_pend_pause ? ST_PAUSED : ST_RUN;
      end
      default: w_state_nxt = ST_RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hcount  <= '0;
      r_vcount  <= '0;
      r_hsync_n <= 1'b1;
      r_vsync_n <= 1'b1;
      r_disp    <= 1'b0;
      r_src_x   <= '0;
      r_src_y   <= '0;
      r_tick    <= 1'b0;
    end else if (ena) begin
      if (w_h_last) begin
        r_hcount <= '0;
        r_vcount <= w_v_last ? '0 : r_vcount + 1'b1;
      end else begin
        r_hcount <= r_hcount + 1'b1;
      end
      r_hsync_n <= !w_hs_act;
      r_vsync_n <= !w_vs_act;
      r_disp    <= w_visible;
      r_src_x   <= w_visible ? w_sx : '0;
      r_src_y   <= w_visible ? CW'(r_vcount) : '0;
      r_tick    <= w_wrap;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_scroll     <= '0;
      r_state      <= ST_RUN;
      r_pend_speed <= 3'd1;
      r_pend_dir   <= 1'b0;
      r_pend_pause <= 1'b0;
      r_act_speed  <= 3'd1;
      r_act_dir    <= 1'b0;
    end else if (ena) begin
      r_state <= w_state_nxt;
      if (w_advance) r_scroll <= w_scroll_nxt;
      if (w_wrap) begin
        r_act_speed <= r_pend_speed;
        r_act_dir   <= r_pend_dir;
      end
      if (cfg_load) begin
        r_pend_speed <= cfg_speed;
        r_pend_dir   <= cfg_dir;
        r_pend_pause <= cfg_pause;
      end
    end
  end

  assign hsync_n    = ena ? r_hsync_n : 1'b1;
  assign vsync_n    = ena ? r_vsync_n : 1'b1;
  assign display_on = ena ? r_disp    : 1'b0;
  assign frame_tick = ena ? r_tick    : 1'b0;
  assign src_x      = r_src_x;
  assign src_y      = r_src_y;
  assign scroll_x   = r_scroll;
  assign state      = r_state;

endmodule

// File: tb/tb_scroll_timing_ctrl.sv
// Randomized bench for scroll_timing_ctrl on a shrunken raster, checked every cycle against a frame-position model.
module tb_scroll_timing_ctrl;

  localparam int HA = 16, HFP = 2, HSW = 3, HBP = 3;
  localparam int VA = 8,  VFP = 2, VSW = 2, VBP = 2;
  localparam int CW = 10;
  localparam int HT = HA + HFP + HSW + HBP;
  localparam int VT = VA + VFP + VSW + VBP;
  localparam int FT = HT * VT;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic ena = 1'b1;
  logic [2:0] cfg_speed = 3'd0;
  logic cfg_dir = 1'b0, cfg_pause = 1'b0, cfg_load = 1'b0, cfg_step = 1'b0;
  logic hsync_n, vsync_n, display_on, frame_tick;
  logic [CW-1:0] src_x, src_y, scroll_x;
  logic [1:0] state;

  scroll_timing_ctrl #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSW), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSW), .V_BP(VBP), .CW(CW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena),
    .cfg_speed(cfg_speed), .cfg_dir(cfg_dir), .cfg_pause(cfg_pause),
    .cfg_load(cfg_load), .cfg_step(cfg_step),
    .hsync_n(hsync_n), .vsync_n(vsync_n), .display_on(display_on),
    .src_x(src_x), .src_y(src_y), .scroll_x(scroll_x),
    .frame_tick(frame_tick), .state(state)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: observed %0d, expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // Model: a single position within the frame, plus the config/pause semantics.
  int m_pos = 0, m_scroll = 0;
  int m_speed = 1, m_dir = 0, p_speed = 1, p_dir = 0, p_pause = 0;
  int m_paused = 0, m_armed = 0;
  int e_hs = 1, e_vs = 1, e_de = 0, e_sx = 0, e_sy = 0, e_tick = 0;
  int mh, mv;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_pos = 0; m_scroll = 0;
      m_speed = 1; m_dir = 0; p_speed = 1; p_dir = 0; p_pause = 0;
      m_paused = 0; m_armed = 0;
      e_hs = 1; e_vs = 1; e_de = 0; e_sx = 0; e_sy = 0; e_tick = 0;
    end else if (ena) begin
      mh = m_pos % HT;
      mv = m_pos / HT;
      e_hs   = (mh >= HA + HFP && mh < HA + HFP + HSW) ? 0 : 1;
      e_vs   = (mv >= VA + VFP && mv < VA + VFP + VSW) ? 0 : 1;
      e_de   = (mh < HA && mv < VA) ? 1 : 0;
      e_sx   = e_de ? (mh + m_scroll) % HA : 0;
      e_sy   = e_de ? mv : 0;
      e_tick = (m_pos == FT - 1) ? 1 : 0;
      if (m_pos == FT - 1) begin
        if (!m_paused || m_armed)
          m_scroll = m_dir ? (m_scroll + HA - m_speed) % HA : (m_scroll + m_speed) % HA;
        m_speed = p_speed;
        m_dir   = p_dir;
        if (m_paused && !m_armed && cfg_step) m_armed = 1;
        else begin
          m_paused = p_pause;
          m_armed  = 0;
        end
      end else if (m_paused && !m_armed && cfg_step) begin
        m_armed = 1;
      end
      if (cfg_load) begin
        p_speed = int'(cfg_speed);
        p_dir   = int'(cfg_dir);
        p_pause = int'(cfg_pause);
      end
      m_pos = (m_pos + 1) % FT;
    end
  end

  // Enabled edges since reset; frame ticks must be exactly one frame of enabled edges apart.
  int n_edges = 0, last_tick = 0;
  always @(posedge clk) if (rst_n && ena) n_edges++;

  always @(negedge clk) begin
    chk("hsync_n",    hsync_n,    ena ? e_hs : 1);
    chk("vsync_n",    vsync_n,    ena ? e_vs : 1);
    chk("display_on", display_on, ena ? e_de : 0);
    chk("frame_tick", frame_tick, ena ? e_tick : 0);
    chk("src_x",      src_x,      e_sx);
    chk("src_y",      src_y,      e_sy);
    chk("scroll_x",   scroll_x,   m_scroll);
    chk("state",      state,      m_armed ? 2 : (m_paused ? 1 : 0));
    if (!rst_n) last_tick = n_edges;
    else if (frame_tick) begin
      chk("tick_period", n_edges - last_tick, FT);
      last_tick = n_edges;
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  initial begin
    repeat (3) tick();
    rst_n = 1'b1;

    // Default config: three wraps advance by one each; frame 4 starts at source column 3.
    repeat (3 * FT + 1) tick();
    chk("scroll_3f", scroll_x, 3);
    chk("src_x_first", src_x, 3);
    tick();

    // Random traffic: config loads, step strobes, pause requests, enable gaps.
    for (int i = 0; i < 40 * FT; i++) begin
      ena       = ($urandom_range(0, 15) != 0);
      cfg_load  = ($urandom_range(0, 19) == 0);
      cfg_speed = 3'($urandom_range(0, 7));
      cfg_dir   = 1'($urandom_range(0, 1));
      cfg_pause = ($urandom_range(0, 2) == 0);
      cfg_step  = ($urandom_range(0, 7) == 0);
      tick();
    end
    ena = 1'b1; cfg_load = 1'b0; cfg_step = 1'b0;

    // Load exactly on the wrap edge: new speed only takes effect one frame later.
    for (int i = 0; i < FT + 2 && m_pos != FT - 1; i++) tick();
    chk("wrap_align", m_pos, FT - 1);
    cfg_load = 1'b1; cfg_speed = 3'd5; cfg_dir = 1'b0; cfg_pause = 1'b0;
    tick();
    cfg_load = 1'b0;
    repeat (2 * FT + 3) tick();

    // Mid-line freeze.
    for (int i = 0; i < HT + 2 && (m_pos % HT) != 5; i++) tick();
    ena = 1'b0;
    repeat (50) tick();
    chk("freeze_hs", hsync_n, 1);
    chk("freeze_vs", vsync_n, 1);
    ena = 1'b1;
    repeat (FT) tick();

    // Asynchronous reset in the middle of a frame.
    for (int i = 0; i < FT + 2 && m_pos != FT / 2; i++) tick();
    rst_n = 1'b0;
    #1;
    chk("rst_hsync", hsync_n, 1);
    chk("rst_vsync", vsync_n, 1);
    chk("rst_de",    display_on, 0);
    chk("rst_srcx",  src_x, 0);
    chk("rst_srcy",  src_y, 0);
    chk("rst_scroll", scroll_x, 0);
    chk("rst_tick",  frame_tick, 0);
    chk("rst_state", state, 0);
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (2 * FT + 5) tick();
    chk("post_rst_scroll", scroll_x, 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/scroll_timing_ctrl.md
Name: scroll_timing_ctrl

Overview:
- Sequencer for the scroller pixel datapath.
- Generates 640x480@60 VGA timing (25.175 MHz pixel clock) and the per-pixel source coordinate.
- Owns the horizontal scroll offset and advances it once per frame under a run/pause/step state machine.
- Latches user configuration and applies it only at frame boundaries, so the picture never tears.

Parameters:
- H_ACTIVE, 640, visible pixels per line.
- H_FP, 16, horizontal front porch.
- H_SYNC, 96, hsync width.
- H_BP, 48, horizontal back porch.
- V_ACTIVE, 480, visible lines.
- V_FP, 10, vertical front porch.
- V_SYNC, 2, vsync width.
- V_BP, 33, vertical back porch.
- CW, 10, coordinate/offset width.

Ports:
- clk  in  1  pixel clock
- rst_n  in  1  asynchronous active-low reset
- ena  in  1  design enable; low freezes the block
- cfg_speed  in  3  pixels advanced per frame (0-7)
- cfg_dir  in  1  0 = content moves left (offset increments), 1 = right (offset decrements)
- cfg_pause  in  1  requested pause state
- cfg_load  in  1  one-cycle strobe; captures cfg_speed/cfg_dir/cfg_pause into pending registers
- cfg_step  in  1  one-cycle strobe; single-frame advance while paused
- hsync_n  out  1  horizontal sync, active low
- vsync_n  out  1  vertical sync, active low
- display_on  out  1  high in the visible region
- src_x  out  CW  (hcount + scroll_x) mod H_ACTIVE when visible, else 0
- src_y  out  CW  vcount when visible, else 0
- scroll_x  out  CW  current offset, 0..H_ACTIVE-1
- frame_tick  out  1  one-cycle pulse marking the frame wrap
- state  out  2  FSM state: 0 RUN, 1 PAUSED, 2 STEP_ARMED

Behaviour:
- Counters:
  - hcount runs 0..H_TOT-1, where H_TOT = 800.
  - vcount increments when hcount wraps and runs 0..V_TOT-1, where V_TOT = 525.
- Output decodes are registered, one cycle of latency after the counters:
  - hsync_n = 0 for hcount in [656,751].
  - vsync_n = 0 for vcount in [490,491].
  - display_on = (hcount < 640) && (vcount < 480).
  - src_x and src_y follow the same one-cycle latency.
- Frame wrap edge: the clock edge where hcount = 799 and vcount = 524. frame_tick is high on the cycle after that edge, i.e. it is the registered version of the wrap condition.
- Reset values (async, rst_n = 0):
  - hcount = 0, vcount = 0, scroll_x = 0.
  - hsync_n = 1, vsync_n = 1, display_on = 0, src_x = 0, src_y = 0, frame_tick = 0.
  - Pending config: speed = 1, dir = 0, pause = 0. Active config is the same.
  - state = RUN.
- Reset mid-frame aborts the frame immediately. Counting restarts at (0,0) on the first edge after rst_n rises.
- ena = 0:
  - All registers hold, including counters, FSM and pending config.
  - cfg_load and cfg_step are ignored.
  - Outputs forced hsync_n = 1, vsync_n = 1, display_on = 0, frame_tick = 0.
- cfg_load: on any edge with cfg_load = 1 and ena = 1, the pending registers capture the inputs. The last load before a frame wrap wins.
- At the frame wrap edge, in this order:
  1. The offset update uses the active config from before the edge.
  2. The active config then takes the pending config.
  A load on the wrap edge itself therefore lands in pending and becomes active at the following wrap.
- Offset arithmetic:
  - dir = 0: scroll_x <= (scroll_x + speed) mod 640.
  - dir = 1: scroll_x <= (scroll_x + 640 - speed) mod 640.
  - Compute in CW+1 bits and subtract 640 when the result is >= 640; never use a power-of-two wrap.
- FSM (evaluated only at the frame wrap edge, except for the step arming):
  - RUN: advance the offset. Go to PAUSED if the newly active pause = 1.
  - PAUSED: no advance. cfg_step = 1 (any cycle) -> STEP_ARMED. At the wrap, if the newly active pause = 0 -> RUN.
  - STEP_ARMED: at the wrap, advance once, then go to PAUSED, or RUN if pause = 0. Repeated cfg_step in STEP_ARMED is ignored, so at most one advance per frame.
  - cfg_step in RUN is ignored.
  - cfg_step on the wrap edge while PAUSED arms STEP_ARMED for the next wrap and does not advance this frame.
- speed = 0 leaves the offset unchanged, including in STEP_ARMED.

Test Plan:
- Reset, ena = 1, run 2 frames -> hsync_n low for exactly 96 cycles per line; vsync_n low for exactly 1600 cycles; frame_tick period 420000 cycles; display_on high for 307200 cycles per frame.
- Default config for 3 frames -> scroll_x = 1, 2, 3 after successive frame_tick; src_x at the first visible pixel of frame 4 is 3.
- Load speed = 7, dir = 0 with scroll_x = 637, then take a wrap -> scroll_x = 4. Load dir = 1 with scroll_x = 3 and speed = 7 -> scroll_x = 636.
- Load pause = 1 mid-frame -> frame wrap still advances by the old speed, state = PAUSED. The next wrap holds scroll_x. cfg_step then gives exactly +speed at the following wrap, and state returns to PAUSED.
- Load on the exact wrap edge -> new speed takes effect one frame later. ena = 0 for 1000 cycles mid-line -> counters resume from the same hcount/vcount, and syncs are high during the freeze.
- Assert rst_n = 0 mid-frame with scroll_x = 200 -> all outputs take their reset values asynchronously; after release, scroll_x = 0 and the first frame_tick occurs 420000 cycles later.
